// File: rtl/aes_rx_packer.sv
// aes_rx_packer: collects 16 UART bytes into a 128-bit block and hands it to
// the encryption stage with a valid/ready handshake. A partial block that sits
// idle for TIMEOUT_CYCLES cycles is discarded. A byte that arrives while a full
// block waits and is not taken in that cycle is dropped and flagged.
module aes_rx_packer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [3:0]   byte_cnt,
  output logic         overrun,
  output logic         timeout
);

  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [127:0]  sh;
  logic [IW-1:0] idle_cnt;

  logic accept;    // byte is taken into the shift register
  logic complete;  // accepted byte is the 16th of the block
  logic drop;      // byte lost while a block waits
  logic xfer;      // block handed downstream
  logic idle;      // idle cycle that advances the idle counter
  logic fire;      // partial block is discarded on this edge

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    drop       = 1'b0;
    xfer       = 1'b0;
    idle       = 1'b0;
    fire       = 1'b0;
    case (state)
      FILL: begin
        if (rx_valid) begin
          // A byte always beats a timeout landing in the same cycle.
          accept = 1'b1;
          if (byte_cnt == 4'd15) begin
            complete   = 1'b1;
            state_next = HOLD;
          end else begin
            complete   = 1'b0;
          end
        end else if (byte_cnt != 4'd0) begin
          idle = 1'b1;
          if (idle_cnt == IDLE_MAX) begin
            fire = 1'b1;
          end else begin
            fire = 1'b0;
          end
        end else begin
          idle = 1'b0;
        end
      end
      HOLD: begin
        if (blk_ready) begin
          // A byte in the transfer cycle starts the next block.
          xfer       = 1'b1;
          accept     = rx_valid;
          state_next = FILL;
        end else begin
          drop = rx_valid;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Datapath: shift register, byte count, idle counter, block and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh        <= 128'd0;
      idle_cnt  <= '0;
      byte_cnt  <= 4'd0;
      blk_data  <= 128'd0;
      blk_valid <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      overrun <= drop;
      timeout <= fire;

      if (accept) begin
        sh <= {sh[119:0], rx_data};
      end else if (fire) begin
        sh <= 128'd0;
      end

      if (complete || fire) begin
        byte_cnt <= 4'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 4'd1;
      end

      // Counter is held at zero whenever it is not counting idle cycles,
      // and fire resets it at IDLE_MAX so it never wraps.
      if (idle && !fire) begin
        idle_cnt <= idle_cnt + IW'(1);
      end else begin
        idle_cnt <= '0;
      end

      if (complete) begin
        blk_data  <= {sh[119:0], rx_data};
        blk_valid <= 1'b1;
      end else if (xfer) begin
        blk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/aes_rx_packer.md
# aes_rx_packer

Byte-to-block packer between the UART receiver and `AES_Encrypt`. It collects 16 received bytes into a 128-bit plaintext block and presents the block with a valid/ready handshake to the encryption stage. It also discards stale partial blocks after an inter-byte timeout and flags bytes lost while a block is waiting. Its output feeds the 128-bit `in` port of `AES_Encrypt`.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 100000: number of consecutive idle cycles after which a partial block is discarded. Legal range ≥ 2.

Ports:
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx_data`  in  8: received byte from the UART RX.
- `rx_valid`  in  1: single-cycle strobe; `rx_data` is valid in this cycle.
- `blk_data`  out  128: assembled block. The first received byte is at [127:120]; the 16th byte is at [7:0].
- `blk_valid`  out  1: `blk_data` holds a complete block that has not yet been taken.
- `blk_ready`  in  1: the downstream stage accepts the block.
- `byte_cnt`  out  4: number of bytes held in the current partial block (0..15).
- `overrun`  out  1: one-cycle pulse when a byte is dropped.
- `timeout`  out  1: one-cycle pulse when a partial block is discarded.

## Operation

- The block has two states: FILL and HOLD. Reset enters FILL.
- FILL, on `rx_valid`:
  - The byte is shifted into a 128-bit shift register: `sh <= {sh[119:0], rx_data}`.
  - `byte_cnt` increments.
  - The idle counter clears.
- FILL, on the 16th byte (`rx_valid` while `byte_cnt`==15):
  - `blk_data <= {sh[119:0], rx_data}`.
  - `blk_valid <= 1`, `byte_cnt <= 0`, state goes to HOLD.
- HOLD:
  - `blk_data` is stable.
  - The transfer occurs on the cycle where `blk_valid && blk_ready`. After that edge, `blk_valid` is 0 and the state returns to FILL.
  - `rx_valid` in HOLD without a same-cycle transfer: the byte is dropped, `overrun` pulses, and all state is otherwise unchanged.
  - `rx_valid` in the same cycle as the transfer: the byte is accepted as byte 0 of the next block (`byte_cnt` becomes 1). `overrun` does not pulse.
- Timeout:
  - The idle counter counts only in FILL with `byte_cnt` > 0, and only in cycles without `rx_valid`.
  - When the idle counter reaches `TIMEOUT_CYCLES`-1 and another idle cycle occurs, the following happen on that edge: `byte_cnt <= 0`, the shift register clears, the idle counter clears, and `timeout` pulses.
  - The idle counter is held at 0 when `byte_cnt`==0 or in HOLD.
- `rx_valid` in the same cycle the timeout would fire: the byte wins. It is counted normally and no timeout occurs.
- `blk_ready` is ignored when `blk_valid` is 0.
- `blk_data` keeps the last completed block after a transfer until the next block completes.
- The idle counter width is $clog2(`TIMEOUT_CYCLES`). It never wraps.

## Timing

- Reset values: `blk_data`=0, `blk_valid`=0, `byte_cnt`=0, `overrun`=0, `timeout`=0. The shift register, idle counter and state (FILL) are also reset.
- Reset takes effect immediately and asynchronously. Reset mid-block or mid-HOLD discards everything.
- All outputs are registered.
- Latency: `blk_valid` rises on the clock edge that samples the 16th `rx_valid`, so it is visible 1 cycle after the strobe cycle.
- `byte_cnt` updates on the edge that samples `rx_valid`.
- `overrun` and `timeout` are high for exactly 1 cycle, in the cycle after the triggering edge.
- Back-to-back `rx_valid` on consecutive cycles is supported in FILL with no bubbles.
- `AES_Encrypt` is combinational. The consumer samples its `out` at least one cycle after taking `blk_data`.

## Test plan

- Reset, then bytes 0x00..0x0F on 16 consecutive cycles, `blk_ready`=0 → `blk_valid` rises 1 cycle after the last strobe; `blk_data`=128'h000102030405060708090A0B0C0D0E0F; `byte_cnt`=0.
- From the previous state, hold `blk_ready`=0 and send byte 0xAA → `overrun` pulses 1 cycle; `blk_data` unchanged; `byte_cnt`=0. Then raise `blk_ready` for 1 cycle → `blk_valid`=0 next cycle.
- While HOLD, assert `blk_ready` and `rx_valid`(0x55) in the same cycle → no `overrun`; `byte_cnt`=1. After 15 more bytes, `blk_data`[127:120]=0x55.
- `TIMEOUT_CYCLES`=8: send 5 bytes, then idle → after 8 idle cycles `timeout` pulses; `byte_cnt`=0. A subsequent 16-byte burst produces a clean block that contains none of the stale bytes.
- `TIMEOUT_CYCLES`=8: 5 bytes, 7 idle cycles, then a byte exactly on the would-fire cycle → no `timeout`; `byte_cnt`=6.
- Assert `rst` asynchronously mid-cycle with `byte_cnt`=9 and with `blk_valid`=1 → all outputs return to 0 immediately. The next 16 bytes form a correct block.
